rom_loader: RTL

Serial program loader that sits directly upstream of the instruction ROM in the Harvard build. It consumes a byte stream from the UART receiver, frames it into 32-bit little-endian words and drives the ROM's write-enable/address/data port, one word per write. While a load is in progress it holds the core; on completion it returns a one-byte ACK or NAK to the UART transmitter.

---
 rtl/rom_loader_pkg.sv | 24 ++
 rtl/rom_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg
//   Shared constants and types for the serial ROM loader: bus widths of the
//   instruction ROM write port, the framing bytes (magic, ACK, NAK) and the
//   loader state encoding exposed on the debug port.
package rom_loader_pkg;

    localparam int MemAddrBus = 32;    // ROM byte-address width
    localparam int MemBus     = 32;    // ROM data width
    localparam int RomNum     = 4096;  // ROM depth in words

    localparam logic [7:0] LOADER_MAGIC = 8'h5A;
    localparam logic [7:0] LOADER_ACK   = 8'h06;
    localparam logic [7:0] LOADER_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CKSUM = 3'd4,
        ST_RESP  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/rom_loader.sv
// rom_loader
//   Frames a UART byte stream (5A, count_lo, count_hi, count x 4 data bytes
//   LSB first, optional checksum) into 32-bit ROM writes, holds the core while
//   a frame is open and answers with a one-byte ACK/NAK.
//
//   Optional feature macro: ROM_LOADER_CKSUM_EN
//     defined   : a trailing XOR checksum byte is expected and compared.
//     undefined : no checksum byte; the last data word directly ACKs.
//
// Ports
//   clk, rst         clock, synchronous active-low reset
//   en_i             gates frame start only
//   rx_valid_i/data  received byte strobe and value
//   rom_we_o         one-cycle write pulse, rom_addr_o/rom_data_o valid with it
//   hold_o           high while a frame is open
//   tx_valid_o/data  response strobe and byte (ACK 06 / NAK 15)
//   done_o, err_o    sticky result flags, cleared at next frame start
//   dbg_state_o      current loader state
//
// Handshake: rx_valid_i is a single-cycle strobe with no back-pressure; a byte
// is consumed in every cycle it is high, including back-to-back cycles.
// rom_we_o and tx_valid_o are single-cycle strobes with no ready.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [MemAddrBus-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                    MAX_WORDS   = RomNum,
    parameter int                    TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rom_we_o,
    output logic [MemAddrBus-1:0] rom_addr_o,
    output logic [MemBus-1:0]     rom_data_o,
    output logic                  hold_o,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    output logic                  done_o,
    output logic                  err_o,
    output loader_state_t         dbg_state_o
);

    localparam int          TMO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0] MAX_WORDS_U = MAX_WORDS;

    loader_state_t           r_state;
    loader_state_t           w_state_nxt;
    logic                    w_resp_ack;
    logic                    w_resp;
    logic                    w_in_frame;
    logic                    w_timeout;
    logic                    w_last_byte;
    logic                    w_last_word;
    logic [15:0]             w_count_full;

    logic [15:0]             r_count;
    logic [15:0]             r_word_idx;
    logic [1:0]              r_byte_idx;
    logic [23:0]             r_word;     // bytes 0..2 of the word being assembled
    logic [TMO_W-1:0]        r_tmo;
    logic                    r_we;
    logic [MemAddrBus-1:0]   r_addr;
    logic [MemBus-1:0]       r_data;
    logic [7:0]              r_tx_data;
    logic                    r_done;
    logic                    r_err;
`ifdef ROM_LOADER_CKSUM_EN
    logic [7:0]              r_cksum;
`endif

    assign w_in_frame = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                        (r_state == ST_DATA) || (r_state == ST_CKSUM);
    // Entering RESP is the single point where the response is decided.
    assign w_resp     = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_resp_ack   = 1'b0;
        w_count_full = {rx_data_i, r_count[7:0]};
        w_last_byte  = (r_byte_idx == 2'd3);
        w_last_word  = (r_word_idx == (r_count - 16'd1));
        // Fires on the TIMEOUT_CYC-th consecutive idle cycle inside a frame.
        w_timeout    = w_in_frame && !rx_valid_i &&
                       (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
        case (r_state)
            ST_IDLE: begin
                if (rx_valid_i && en_i && (rx_data_i == LOADER_MAGIC))
                    w_state_nxt = ST_LEN0;
            end
            ST_LEN0: begin
                if (rx_valid_i)     w_state_nxt = ST_LEN1;
                else if (w_timeout) w_state_nxt = ST_RESP;
            end
            ST_LEN1: begin
                if (rx_valid_i) begin
                    if ({16'd0, w_count_full} > MAX_WORDS_U) begin
                        w_state_nxt = ST_RESP;
                    end else if (w_count_full == 16'd0) begin
`ifdef ROM_LOADER_CKSUM_EN
                        w_state_nxt = ST_CKSUM;
`else
                        w_state_nxt = ST_RESP;
                        w_resp_ack  = 1'b1;
`endif
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_DATA: begin
                if (rx_valid_i) begin
                    if (w_last_byte && w_last_word) begin
`ifdef ROM_LOADER_CKSUM_EN
                        w_state_nxt = ST_CKSUM;
`else
                        w_state_nxt = ST_RESP;
                        w_resp_ack  = 1'b1;
`endif
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
`ifdef ROM_LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (rx_valid_i) begin
                    w_state_nxt = ST_RESP;
                    w_resp_ack  = (rx_data_i == r_cksum);
                end else if (w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
`endif
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_tmo      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_tx_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef ROM_LOADER_CKSUM_EN
            r_cksum    <= '0;
`endif
        end else begin
            r_we <= 1'b0;

            if (rx_valid_i || !w_in_frame) r_tmo <= '0;
            else                           r_tmo <= r_tmo + 1'b1;

            if ((r_state == ST_IDLE) && (w_state_nxt == ST_LEN0)) begin
                r_done     <= 1'b0;
                r_err      <= 1'b0;
                r_word_idx <= '0;
                r_byte_idx <= '0;
`ifdef ROM_LOADER_CKSUM_EN
                r_cksum    <= '0;
`endif
            end

            if (rx_valid_i && (r_state == ST_LEN0)) r_count[7:0]  <= rx_data_i;
            if (rx_valid_i && (r_state == ST_LEN1)) r_count[15:8] <= rx_data_i;

            if (rx_valid_i && (r_state == ST_DATA)) begin
`ifdef ROM_LOADER_CKSUM_EN
                r_cksum    <= r_cksum ^ rx_data_i;
`endif
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0: r_word[7:0]   <= rx_data_i;
                    2'd1: r_word[15:8]  <= rx_data_i;
                    2'd2: r_word[23:16] <= rx_data_i;
                    default: begin
                        r_we       <= 1'b1;
                        r_addr     <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
                        r_data     <= {rx_data_i, r_word};
                        r_word_idx <= r_word_idx + 16'd1;
                    end
                endcase
            end

            if (w_resp) begin
                r_tx_data <= w_resp_ack ? LOADER_ACK : LOADER_NAK;
                r_done    <= w_resp_ack;
                r_err     <= !w_resp_ack;
            end
        end
    end

    assign rom_we_o    = r_we;
    assign rom_addr_o  = r_addr;
    assign rom_data_o  = r_data;
    assign hold_o      = w_in_frame;
    assign tx_valid_o  = (r_state == ST_RESP);
    assign tx_data_o   = r_tx_data;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

endmodule
